// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, control codes and port index type for the dram arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
    localparam logic [2:0] CTRL_NOP = 3'b000;
    typedef logic port_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-port round-robin winner select with optional owner lock
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last_grant,
    input  logic       lock_valid,
    input  port_t      lock_owner,
    output logic       gnt_valid,
    output port_t      gnt_id
);
    logic [1:0] elig;
    always_comb begin
        elig      = lock_valid ? (req & (lock_owner ? 2'b10 : 2'b01)) : req;
        gnt_valid = |elig;
        gnt_id    = (elig == 2'b11) ? ~last_grant : elig[1];
    end
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the dram_ctrl data port between two req/ack requesters
module dram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int ACC_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic [2:0]    m0_rd_ctrl,
    input  logic [2:0]    m0_wr_ctrl,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_din,
    output logic          m0_ack,
    output logic [DW-1:0] m0_dout,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic [2:0]    m1_rd_ctrl,
    input  logic [2:0]    m1_wr_ctrl,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_din,
    output logic          m1_ack,
    output logic [DW-1:0] m1_dout,
    output logic [2:0]    dm_rd_ctrl,
    output logic [2:0]    dm_wr_ctrl,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    input  logic [DW-1:0] dm_dout,
    output logic          busy,
    output logic          grant_id
);
    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    port_t         grant_q, grant_d, last_q, last_d, lko_q, lko_d;
    logic          lkv_q, lkv_d, lkr_q, lkr_d;
    logic [2:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d, d0_q, d0_d, d1_q, d1_d;
    logic          win_v, act;
    port_t         win_id;
    logic [2:0]    sel_rd, sel_wr;

    rr_arbiter2 u_rr (
        .req        ({m1_req, m0_req}),
        .last_grant (last_q),
        .lock_valid (lkv_q),
        .lock_owner (lko_q),
        .gnt_valid  (win_v),
        .gnt_id     (win_id)
    );

    // a write wins over a simultaneous read, so the read code is dropped at capture
    assign sel_wr = win_id ? m1_wr_ctrl : m0_wr_ctrl;
    assign sel_rd = (sel_wr != CTRL_NOP) ? CTRL_NOP : (win_id ? m1_rd_ctrl : m0_rd_ctrl);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        lkv_d   = lkv_q;
        lko_d   = lko_q;
        lkr_d   = lkr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        case (state_q)
            IDLE: if (win_v) begin
                state_d = ISSUE;
                cnt_d   = '0;
                grant_d = win_id;
                rd_d    = sel_rd;
                wr_d    = sel_wr;
                addr_d  = win_id ? m1_addr : m0_addr;
                din_d   = win_id ? m1_din : m0_din;
                lkr_d   = win_id ? m1_lock : m0_lock;
            end
            ISSUE: if (cnt_q == 8'(ACC_CYC - 1)) begin
                state_d = RESP;
                d0_d    = (rd_q != CTRL_NOP && !grant_q) ? dm_dout : d0_q;
                d1_d    = (rd_q != CTRL_NOP && grant_q) ? dm_dout : d1_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            RESP: begin
                state_d = IDLE;
                last_d  = grant_q;
                lkv_d   = lkr_q;
                lko_d   = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            lkv_q   <= 1'b0;
            lko_q   <= 1'b0;
            lkr_q   <= 1'b0;
            rd_q    <= CTRL_NOP;
            wr_q    <= CTRL_NOP;
            addr_q  <= '0;
            din_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            lkv_q   <= lkv_d;
            lko_q   <= lko_d;
            lkr_q   <= lkr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end

    // a no-op access keeps the whole downstream bus quiet
    assign act        = (state_q == ISSUE) && (rd_q != CTRL_NOP || wr_q != CTRL_NOP);
    assign dm_rd_ctrl = act ? rd_q : CTRL_NOP;
    assign dm_wr_ctrl = act ? wr_q : CTRL_NOP;
    assign dm_addr    = act ? addr_q : '0;
    assign dm_din     = act ? din_q : '0;
    assign m0_ack     = (state_q == RESP) && !grant_q;
    assign m1_ack     = (state_q == RESP) && grant_q;
    assign m0_dout    = d0_q;
    assign m1_dout    = d1_q;
    assign busy       = state_q != IDLE;
    assign grant_id   = grant_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed vectors with hand-computed expectations for dram_arbiter
module tb_dram_arbiter;
    logic        clk, rst;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [2:0]  m0_rd_ctrl, m0_wr_ctrl, m1_rd_ctrl, m1_wr_ctrl;
    logic [63:0] m0_addr, m0_din, m1_addr, m1_din, m0_dout, m1_dout;
    logic        m0_ack, m1_ack, busy, grant_id;
    logic [2:0]  dm_rd_ctrl, dm_wr_ctrl;
    logic [63:0] dm_addr, dm_din, dm_dout;
    int          n_vec = 0, n_err = 0;

    dram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_rd_ctrl(m0_rd_ctrl), .m0_wr_ctrl(m0_wr_ctrl),
        .m0_addr(m0_addr), .m0_din(m0_din), .m0_ack(m0_ack), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_rd_ctrl(m1_rd_ctrl), .m1_wr_ctrl(m1_wr_ctrl),
        .m1_addr(m1_addr), .m1_din(m1_din), .m1_ack(m1_ack), .m1_dout(m1_dout),
        .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_dout(dm_dout), .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input bit p, input bit rq, input bit lk, input logic [2:0] rd,
                            input logic [2:0] wr, input logic [63:0] addr, input logic [63:0] din);
        if (p) begin
            m1_req = rq; m1_lock = lk; m1_rd_ctrl = rd; m1_wr_ctrl = wr; m1_addr = addr; m1_din = din;
        end else begin
            m0_req = rq; m0_lock = lk; m0_rd_ctrl = rd; m0_wr_ctrl = wr; m0_addr = addr; m0_din = din;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_port(0, 0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0, 0);
        dm_dout = '0;
        repeat (2) @(negedge clk);
        chk("rst_dm_rd", dm_rd_ctrl, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
        chk("rst_dout0", m0_dout, 0);
        chk("rst_dout1", m1_dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // one isolated access from port p; call at a negedge with the other port idle
    task automatic access(input bit p, input logic [2:0] rd, input logic [2:0] wr,
                          input logic [63:0] addr, input logic [63:0] din,
                          input logic [63:0] dd, input logic [63:0] exp_dout);
        logic        nz;
        logic [63:0] ea, ed;
        nz = (rd != 0) || (wr != 0);
        ea = nz ? addr : 64'd0;
        ed = nz ? din : 64'd0;
        set_port(p, 1, 0, rd, wr, addr, din);
        dm_dout = dd;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("iss_rd", dm_rd_ctrl, (wr != 0) ? 3'd0 : rd);
            chk("iss_wr", dm_wr_ctrl, wr);
            chk("iss_addr", dm_addr, ea);
            chk("iss_din", dm_din, ed);
            chk("iss_ack", {m0_ack, m1_ack}, 0);
        end
        @(negedge clk);
        chk("resp_ack", {m1_ack, m0_ack}, p ? 2'b10 : 2'b01);
        chk("resp_dm", {dm_rd_ctrl, dm_wr_ctrl}, 0);
        chk("resp_gid", grant_id, p);
        chk("resp_dout", p ? m1_dout : m0_dout, exp_dout);
        set_port(p, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle_ack", {m0_ack, m1_ack}, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic wait_ack(output int who);
        who = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_ack) begin who = 0; break; end
            if (m1_ack) begin who = 1; break; end
        end
    endtask

    initial begin
        int who, seen;
        rst = 1'b1;
        do_reset();
        access(0, 3'b011, 0, 64'h40, 0, 64'hDEADBEEF, 64'hDEADBEEF);
        access(1, 3'b001, 0, 64'h10, 0, 64'hA5A5, 64'hA5A5);
        access(1, 0, 3'b001, 64'h8, 64'h55, 64'hFFFF, 64'hA5A5);
        access(0, 3'd2, 3'd1, 64'h20, 64'h77, 64'h1111, 64'hDEADBEEF);
        access(1, 0, 0, 64'h30, 64'h99, 64'h2222, 64'hA5A5);

        do_reset();
        set_port(0, 1, 0, 3'd1, 0, 64'h100, 0);
        set_port(1, 1, 0, 3'd1, 0, 64'h200, 0);
        dm_dout = 64'h77;
        for (int i = 0; i < 4; i++) begin
            wait_ack(who);
            chk("rr_order", 64'(who), 64'(i % 2));
        end
        set_port(0, 0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        set_port(0, 1, 1, 3'd1, 0, 64'h300, 0);
        wait_ack(who);
        chk("lock_take", 64'(who), 0);
        set_port(0, 0, 0, 0, 0, 0, 0);
        set_port(1, 1, 0, 3'd1, 0, 64'h400, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (m1_ack || busy) seen = 1;
        end
        chk("lock_block", 64'(seen), 0);
        set_port(0, 1, 0, 3'd1, 0, 64'h308, 0);
        wait_ack(who);
        chk("lock_release", 64'(who), 0);
        set_port(0, 0, 0, 0, 0, 0, 0);
        wait_ack(who);
        chk("lock_after", 64'(who), 1);
        set_port(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        do_reset();
        set_port(1, 1, 0, 3'd1, 0, 64'h500, 0);
        dm_dout = 64'hBAD;
        @(negedge clk);
        chk("abort_pre", dm_rd_ctrl, 3'd1);
        rst = 1'b0;
        set_port(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("abort_dm", {dm_rd_ctrl, dm_addr}, 0);
        chk("abort_busy", busy, 0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (m0_ack || m1_ack) seen = 1;
        end
        chk("abort_noack", 64'(seen), 0);
        chk("abort_dout", m1_dout, 0);
        rst = 1'b1;
        @(negedge clk);
        access(1, 3'd1, 0, 64'h500, 0, 64'hC0FFEE, 64'hC0FFEE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
